// File: rtl/nav_pkg.sv
// Shared definitions for the navigation position unit.
//   - one-hot combat mode encodings
//   - jump sequencer state encoding
//   - velocity scaling shift amounts
//   - one-hot validity helper
package nav_pkg;

  localparam logic [3:0] MODE_RESET   = 4'b0001;
  localparam logic [3:0] MODE_ATTACK  = 4'b0010;
  localparam logic [3:0] MODE_DEFENSE = 4'b0100;
  localparam logic [3:0] MODE_STEALTH = 4'b1000;

  localparam int DEFENSE_SHIFT = 1;
  localparam int STEALTH_SHIFT = 2;

  typedef enum logic [1:0] {
    CRUISE = 2'd0,
    CHARGE = 2'd1,
    JUMP   = 2'd2
  } nav_state_e;

  // Exactly one bit set.
  function automatic logic mode_onehot(input logic [3:0] m);
    return (m != 4'd0) && ((m & (m - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/nav_axis.sv
// One axis of the position integrator.
//   clk, rst_n    : clock, async active-low reset
//   mode_i        : one-hot combat mode (selects velocity scaling)
//   speed_i       : signed commanded speed
//   hold_i        : freeze position (jump in progress)
//   load_i        : overwrite position with load_value_i
//   clear_i       : synchronous clear of position and sat flag
//   load_value_i  : jump destination
//   pos_o         : registered signed position
//   sat_o         : sticky saturation flag
module nav_axis
  import nav_pkg::*;
#(
  parameter int K = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   mode_i,
  input  logic [K-1:0] speed_i,
  input  logic         hold_i,
  input  logic         load_i,
  input  logic         clear_i,
  input  logic [K-1:0] load_value_i,
  output logic [K-1:0] pos_o,
  output logic         sat_o
);

  logic signed [K-1:0] vel;
  logic        [K:0]   sum;
  logic                ovf;
  logic        [K-1:0] clamp_val;
  logic        [K-1:0] pos_d, pos_q;
  logic                sat_d, sat_q;

  // RESET and any non-one-hot pattern fall to the default: zero velocity.
  always_comb begin
    vel = '0;
    case (mode_i)
      MODE_ATTACK:  vel = $signed(speed_i);
      MODE_DEFENSE: vel = $signed(speed_i) >>> DEFENSE_SHIFT;
      MODE_STEALTH: vel = $signed(speed_i) >>> STEALTH_SHIFT;
      default:      vel = '0;
    endcase
  end

  // Sign-extended K+1 bit sum; top two bits differ only on overflow, and the
  // top bit then gives the direction of the clamp.
  assign sum       = {pos_q[K-1], pos_q} + {vel[K-1], vel};
  assign ovf       = sum[K] ^ sum[K-1];
  assign clamp_val = sum[K] ? {1'b1, {(K-1){1'b0}}} : {1'b0, {(K-1){1'b1}}};

  always_comb begin
    pos_d = pos_q;
    sat_d = sat_q;
    if (clear_i) begin
      pos_d = '0;
      sat_d = 1'b0;
    end else if (load_i) begin
      pos_d = load_value_i;
    end else if (!hold_i) begin
      pos_d = ovf ? clamp_val : sum[K-1:0];
      sat_d = sat_q | ovf;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q <= '0;
      sat_q <= 1'b0;
    end else begin
      pos_q <= pos_d;
      sat_q <= sat_d;
    end
  end

  assign pos_o = pos_q;
  assign sat_o = sat_q;

endmodule

// File: rtl/nav_position_unit.sv
// N-axis ship position integrator with a charge-then-teleport jump sequencer.
//   clk, rst_n   : clock, async active-low reset
//   mode         : one-hot RESET/ATTACK/DEFENSE/STEALTH
//   speed        : packed signed speed per axis, axis 0 in the low K bits
//   jump_req     : jump request, honoured only in CRUISE
//   jump_target  : packed signed destination, captured on acceptance
//   jump_busy    : high while charging or jumping
//   jump_ack     : one-cycle pulse when position first equals the target
//   position     : packed registered position
//   sat_flag     : sticky per-axis saturation
//   mode_err     : registered flag for a non-one-hot mode sample
module nav_position_unit
  import nav_pkg::*;
#(
  parameter int K           = 16,
  parameter int N_AXES      = 3,
  parameter int JUMP_CHARGE = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          mode,
  input  logic [N_AXES*K-1:0] speed,
  input  logic                jump_req,
  input  logic [N_AXES*K-1:0] jump_target,
  output logic                jump_busy,
  output logic                jump_ack,
  output logic [N_AXES*K-1:0] position,
  output logic [N_AXES-1:0]   sat_flag,
  output logic                mode_err
);

  localparam int CW = (JUMP_CHARGE > 1) ? $clog2(JUMP_CHARGE) : 1;

  nav_state_e          state_d, state_q;
  logic [CW-1:0]       cnt_d, cnt_q;
  logic [N_AXES*K-1:0] tgt_d, tgt_q;
  logic                ack_d, ack_q;
  logic                err_q;
  logic                mode_rst;

  assign mode_rst = (mode == MODE_RESET);

  // mode RESET overrides every state, so an in-flight jump dies without ack.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    ack_d   = 1'b0;
    if (mode_rst) begin
      state_d = CRUISE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        CRUISE: if (jump_req) begin
          tgt_d   = jump_target;
          cnt_d   = CW'(JUMP_CHARGE - 1);
          state_d = CHARGE;
        end
        CHARGE: if (cnt_q == '0) state_d = JUMP;
                else             cnt_d   = cnt_q - CW'(1);
        JUMP: begin
          state_d = CRUISE;
          ack_d   = 1'b1;
        end
        default: state_d = CRUISE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CRUISE;
      cnt_q   <= '0;
      tgt_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      ack_q   <= ack_d;
      err_q   <= !mode_onehot(mode);
    end
  end

  for (genvar a = 0; a < N_AXES; a++) begin : g_axis
    nav_axis #(.K(K)) u_axis (
      .clk          (clk),
      .rst_n        (rst_n),
      .mode_i       (mode),
      .speed_i      (speed[a*K +: K]),
      .hold_i       (state_q != CRUISE),
      .load_i       (state_q == JUMP),
      .clear_i      (mode_rst),
      .load_value_i (tgt_q[a*K +: K]),
      .pos_o        (position[a*K +: K]),
      .sat_o        (sat_flag[a])
    );
  end

  assign jump_busy = (state_q != CRUISE);
  assign jump_ack  = ack_q;
  assign mode_err  = err_q;

endmodule
